// File: rtl/tlb_refill_engine.sv
// TLB miss handler: round-robin grant over requesters, one page-table walk at a time, and
// coalesced completion of every port waiting on the walked VPN.
module tlb_refill_engine #(
    parameter int unsigned VA_WIDTH       = 32,
    parameter int unsigned OFFSET_BITS    = 12,
    parameter int unsigned PPN_WIDTH      = 20,
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned VPN_W         = VA_WIDTH - OFFSET_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          miss_valid,
    input  logic [NUM_PORTS*VA_WIDTH-1:0] miss_vaddr,
    output logic [NUM_PORTS-1:0]          miss_done,
    output logic                          miss_fault,
    output logic                          pt_req_valid,
    input  logic                          pt_req_ready,
    output logic [VPN_W-1:0]              pt_req_vpn,
    input  logic                          pt_rsp_valid,
    input  logic [PPN_WIDTH-1:0]          pt_rsp_ppn,
    input  logic                          pt_rsp_fault,
    output logic                          tlb_we,
    output logic [VPN_W-1:0]              tlb_vpn,
    output logic [PPN_WIDTH-1:0]          tlb_ppn,
    output logic                          busy
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StFill, StDoneF} state_t;

    state_t               state_q;
    logic [VPN_W-1:0]     vpn_q;
    logic [PPN_WIDTH-1:0] ppn_q;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     rr_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [VPN_W-1:0]     port_vpn [NUM_PORTS];
    logic [NUM_PORTS-1:0] done_set;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     rr_next;
    logic [IDX_W:0]       scan_sum;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 timeout_hit;

    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            port_vpn[j] = miss_vaddr[j*VA_WIDTH+OFFSET_BITS +: VPN_W];
        end
    end

    // Scan ports starting at the round-robin pointer, wrapping modulo NUM_PORTS.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(NUM_PORTS)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_PORTS);
            end
            if (!grant_found && miss_valid[scan_sum[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[IDX_W-1:0];
            end
        end
    end

    assign rr_next = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

    // Granted port always completes, even if it dropped its request early.
    always_comb begin
        done_set = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            done_set[j] = miss_valid[j] && (port_vpn[j] == vpn_q);
        end
        done_set[grant_q] = 1'b1;
    end

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            vpn_q        <= '0;
            ppn_q        <= '0;
            grant_q      <= '0;
            rr_q         <= '0;
            cnt_q        <= '0;
            pt_req_valid <= 1'b0;
            tlb_we       <= 1'b0;
            miss_done    <= '0;
            miss_fault   <= 1'b0;
        end else begin
            tlb_we     <= 1'b0;
            miss_done  <= '0;
            miss_fault <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        vpn_q        <= port_vpn[grant_idx];
                        grant_q      <= grant_idx;
                        rr_q         <= rr_next;
                        pt_req_valid <= 1'b1;
                        state_q      <= StReq;
                    end
                end
                StReq: begin
                    if (pt_req_ready) begin
                        pt_req_valid <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_inc;
                    // A response arriving on the timeout cycle takes priority.
                    if (pt_rsp_valid && !pt_rsp_fault) begin
                        ppn_q     <= pt_rsp_ppn;
                        tlb_we    <= 1'b1;
                        miss_done <= done_set;
                        state_q   <= StFill;
                    end else if (pt_rsp_valid || timeout_hit) begin
                        miss_done  <= done_set;
                        miss_fault <= 1'b1;
                        state_q    <= StDoneF;
                    end
                end
                StFill, StDoneF: state_q <= StIdle;
                default:         state_q <= StIdle;
            endcase
        end
    end

    assign pt_req_vpn = vpn_q;
    assign tlb_vpn    = vpn_q;
    assign tlb_ppn    = ppn_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_tlb_refill_engine.sv
// Bench for tlb_refill_engine: requester and page-table models drive stimulus; a scoreboard
// queue filled at walk completion is drained by an independent output monitor.
module tb_tlb_refill_engine;
    localparam int unsigned VA_WIDTH       = 32;
    localparam int unsigned OFFSET_BITS    = 12;
    localparam int unsigned PPN_WIDTH      = 20;
    localparam int unsigned NUM_PORTS      = 2;
    localparam int unsigned TIMEOUT_CYCLES = 4;
    localparam int unsigned VPN_W          = VA_WIDTH - OFFSET_BITS;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NUM_PORTS-1:0]          miss_valid;
    logic [NUM_PORTS*VA_WIDTH-1:0] miss_vaddr;
    logic [NUM_PORTS-1:0]          miss_done;
    logic                          miss_fault;
    logic                          pt_req_valid;
    logic                          pt_req_ready;
    logic [VPN_W-1:0]              pt_req_vpn;
    logic                          pt_rsp_valid;
    logic [PPN_WIDTH-1:0]          pt_rsp_ppn;
    logic                          pt_rsp_fault;
    logic                          tlb_we;
    logic [VPN_W-1:0]              tlb_vpn;
    logic [PPN_WIDTH-1:0]          tlb_ppn;
    logic                          busy;

    tlb_refill_engine #(
        .VA_WIDTH      (VA_WIDTH),
        .OFFSET_BITS   (OFFSET_BITS),
        .PPN_WIDTH     (PPN_WIDTH),
        .NUM_PORTS     (NUM_PORTS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .miss_valid  (miss_valid),
        .miss_vaddr  (miss_vaddr),
        .miss_done   (miss_done),
        .miss_fault  (miss_fault),
        .pt_req_valid(pt_req_valid),
        .pt_req_ready(pt_req_ready),
        .pt_req_vpn  (pt_req_vpn),
        .pt_rsp_valid(pt_rsp_valid),
        .pt_rsp_ppn  (pt_rsp_ppn),
        .pt_rsp_fault(pt_rsp_fault),
        .tlb_we      (tlb_we),
        .tlb_vpn     (tlb_vpn),
        .tlb_ppn     (tlb_ppn),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_PORTS-1:0] mask;
        logic                 fault;
        logic [VPN_W-1:0]     vpn;
        logic [PPN_WIDTH-1:0] ppn;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Requester model
    logic             pending [NUM_PORTS];
    logic [VA_WIDTH-1:0] va  [NUM_PORTS];
    logic             reraise [NUM_PORTS];
    int               rr_m = 0;
    int               grant_m = 0;
    logic [VPN_W-1:0] cur_vpn;

    // Page-table model
    int                   phase = 0;
    int                   k_wait = 0;
    int                   d_sel = 1;
    logic                 f_sel = 1'b0;
    logic [PPN_WIDTH-1:0] p_sel = '0;

    // Knobs
    logic                 rand_mode = 1'b0;
    int                   req_pct   = 0;
    int                   ready_pct = 100;
    logic                 force_pt  = 1'b1;
    int                   f_d       = 1;
    logic                 f_fault   = 1'b0;
    logic [PPN_WIDTH-1:0] f_ppn     = '0;

    // Observations
    int                   hs_count = 0;
    int                   we_count = 0;
    logic [VPN_W-1:0]     req_log[$];
    logic [NUM_PORTS-1:0] last_mask = '0;
    logic                 last_fault = 1'b0;
    int                   done_cyc = -1;
    int                   raise_cyc = 0;
    int                   exp_log [5] = '{1, 2, 1, 2, 1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [VPN_W-1:0] vpn_of(input logic [VA_WIDTH-1:0] a);
        return a[VA_WIDTH-1:OFFSET_BITS];
    endfunction

    function automatic logic [VA_WIDTH-1:0] rand_va();
        logic [VPN_W-1:0] v;
        case ($urandom_range(3))
            0:       v = 20'h00001;
            1:       v = 20'h00002;
            2:       v = 20'h7FFFF;
            default: v = VPN_W'($urandom);
        endcase
        return {v, OFFSET_BITS'($urandom)};
    endfunction

    function automatic logic any_pending();
        logic r = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) r = r | pending[i];
        return r;
    endfunction

    task automatic raise(input int i, input logic [VA_WIDTH-1:0] a);
        pending[i] = 1'b1;
        va[i]      = a;
    endtask

    // One clock of stimulus, executed at a falling edge.
    task automatic step();
        logic [NUM_PORTS-1:0] mask;
        if (miss_done != '0 && done_cyc < 0) done_cyc = cyc;
        // Grant prediction uses the request set driven into the grant edge.
        if (phase == 0 && pt_req_valid) begin
            grant_m = -1;
            for (int n = 0; n < NUM_PORTS; n++) begin
                int p = (rr_m + n) % NUM_PORTS;
                if (grant_m < 0 && miss_valid[p]) grant_m = p;
            end
            if (grant_m < 0) begin
                total++;
                bad++;
                $display("FAIL grant_source: got request vpn %0h want no request", pt_req_vpn);
                grant_m = 0;
            end
            cur_vpn = vpn_of(va[grant_m]);
            check("grant_vpn", 64'(pt_req_vpn), 64'(cur_vpn));
            req_log.push_back(pt_req_vpn);
            rr_m  = (grant_m + 1) % NUM_PORTS;
            phase = 1;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (miss_done[i]) begin
                if (reraise[i]) reraise[i] = 1'b0;
                else pending[i] = 1'b0;
            end
            if (!pending[i] && rand_mode && $urandom_range(99) < req_pct) begin
                pending[i] = 1'b1;
                va[i]      = rand_va();
            end
        end
        pt_req_ready = 1'b0;
        pt_rsp_valid = 1'b0;
        pt_rsp_fault = 1'b0;
        pt_rsp_ppn   = PPN_WIDTH'($urandom);
        if (phase == 2) begin
            k_wait++;
            if (k_wait == d_sel || k_wait == int'(TIMEOUT_CYCLES)) begin
                mask = '0;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (pending[i] && vpn_of(va[i]) == cur_vpn) mask[i] = 1'b1;
                end
                mask[grant_m] = 1'b1;
                if (k_wait == d_sel) begin
                    pt_rsp_valid = 1'b1;
                    pt_rsp_fault = f_sel;
                    pt_rsp_ppn   = p_sel;
                    exp_q.push_back('{mask, f_sel, cur_vpn, p_sel});
                end else begin
                    exp_q.push_back('{mask, 1'b1, cur_vpn, p_sel});
                end
                phase = 0;
            end
        end else if (phase == 1) begin
            if (int'($urandom_range(99)) < ready_pct) begin
                pt_req_ready = 1'b1;
                hs_count++;
                if (force_pt) begin
                    d_sel = f_d;
                    f_sel = f_fault;
                    p_sel = f_ppn;
                end else begin
                    d_sel = $urandom_range(1, TIMEOUT_CYCLES + 2);
                    f_sel = ($urandom_range(3) == 0);
                    p_sel = PPN_WIDTH'($urandom);
                end
                k_wait = 0;
                phase  = 2;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            miss_valid[i]                        = pending[i];
            miss_vaddr[i*VA_WIDTH +: VA_WIDTH] = va[i];
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while (!(phase == 0 && exp_q.size() == 0 && !any_pending() && !busy)) begin
            if (n >= limit) begin
                total++;
                bad++;
                $display("FAIL idle_bound: got still busy after %0d cycles want idle", n);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miss_done"},    64'(miss_done),    64'(0));
        check({tag, "_miss_fault"},   64'(miss_fault),   64'(0));
        check({tag, "_pt_req_valid"}, 64'(pt_req_valid), 64'(0));
        check({tag, "_pt_req_vpn"},   64'(pt_req_vpn),   64'(0));
        check({tag, "_tlb_we"},       64'(tlb_we),       64'(0));
        check({tag, "_tlb_vpn"},      64'(tlb_vpn),      64'(0));
        check({tag, "_tlb_ppn"},      64'(tlb_ppn),      64'(0));
        check({tag, "_busy"},         64'(busy),         64'(0));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && (miss_done != '0 || tlb_we)) begin
            if (tlb_we) we_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=%0b we=%0b want no completion",
                         miss_done, tlb_we);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_mask",  64'(miss_done),  64'(mon_e.mask));
                check("done_fault", 64'(miss_fault), 64'(mon_e.fault));
                check("tlb_we",     64'(tlb_we),     64'(!mon_e.fault));
                if (!mon_e.fault) begin
                    check("tlb_vpn", 64'(tlb_vpn), 64'(mon_e.vpn));
                    check("tlb_ppn", 64'(tlb_ppn), 64'(mon_e.ppn));
                end
                last_mask  = miss_done;
                last_fault = miss_fault;
            end
        end
    end

    initial begin
        int hs0;
        int we0;
        int n;
        reset        = 1'b1;
        miss_valid   = '0;
        miss_vaddr   = '0;
        pt_req_ready = 1'b0;
        pt_rsp_valid = 1'b0;
        pt_rsp_ppn   = '0;
        pt_rsp_fault = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pending[i] = 1'b0;
            va[i]      = '0;
            reraise[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // T3: round-robin order; port0 keeps its request high once (a new miss)
        f_d = 1;
        raise(0, 32'h0000_1000);
        raise(1, 32'h0000_2000);
        reraise[0] = 1'b1;
        run_until_idle(100);
        raise(0, 32'h0000_1000);
        raise(1, 32'h0000_2000);
        run_until_idle(100);
        check("t3_walks", 64'(req_log.size()), 64'(5));
        for (int i = 0; i < 5 && i < req_log.size(); i++) begin
            check("t3_order", 64'(req_log[i]), 64'(exp_log[i]));
        end

        // T1: zero-wait page table
        f_d = 1; f_fault = 1'b0; f_ppn = 20'hABCDE;
        raise(0, 32'h1234_5678);
        raise_cyc = cyc;
        done_cyc  = -1;
        run_until_idle(50);
        check("t1_latency", 64'(done_cyc - raise_cyc), 64'(3));
        check("t1_mask",    64'(last_mask), 64'(2'b01));
        check("t1_vpn",     64'(tlb_vpn),   64'(20'h12345));
        check("t1_ppn",     64'(tlb_ppn),   64'(20'hABCDE));

        // T2: timeout, no response
        f_d = 99;
        we0 = we_count;
        raise(1, 32'h0000_1000);
        raise_cyc = cyc;
        done_cyc  = -1;
        run_until_idle(50);
        check("t2_latency", 64'(done_cyc - raise_cyc), 64'(6));
        check("t2_mask",    64'(last_mask),  64'(2'b10));
        check("t2_fault",   64'(last_fault), 64'(1));
        check("t2_no_we",   64'(we_count),   64'(we0));

        // T4: both ports on the same page coalesce into one walk
        f_d = 2; f_ppn = 20'h0ABCD;
        hs0 = hs_count;
        raise(0, 32'h7FFF_F123);
        raise(1, 32'h7FFF_F456);
        run_until_idle(50);
        check("t4_one_req", 64'(hs_count - hs0), 64'(1));
        check("t4_mask",    64'(last_mask),      64'(2'b11));
        check("t4_ppn",     64'(tlb_ppn),        64'(20'h0ABCD));

        // T5: faulting response does not write the TLB
        f_d = 2; f_fault = 1'b1; f_ppn = 20'h12345;
        we0 = we_count;
        raise(0, 32'h0042_0000);
        run_until_idle(50);
        check("t5_fault", 64'(last_fault), 64'(1));
        check("t5_no_we", 64'(we_count),   64'(we0));
        check("t5_ppn",   64'(tlb_ppn),    64'(20'h0ABCD));
        f_fault = 1'b0;

        // T6: reset while waiting, stray response afterwards
        f_d = 99;
        raise(0, 32'h5555_5000);
        n = 0;
        while (!(phase == 2 && k_wait == 2) && n < 30) begin
            step();
            n++;
        end
        check("t6_in_wait", 64'(busy), 64'(1));
        reset = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) pending[i] = 1'b0;
        miss_valid   = '0;
        pt_req_ready = 1'b0;
        exp_q.delete();
        rr_m  = 0;
        phase = 0;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        reset = 1'b0;
        @(negedge clk);
        pt_rsp_valid = 1'b1;
        pt_rsp_ppn   = 20'h11111;
        @(negedge clk);
        pt_rsp_valid = 1'b0;
        repeat (3) begin
            check("t6_done", 64'(miss_done), 64'(0));
            check("t6_we",   64'(tlb_we),    64'(0));
            check("t6_busy", 64'(busy),      64'(0));
            @(negedge clk);
        end
        f_d = 1; f_ppn = 20'h0F0F0;
        raise(1, 32'h0BAD_C000);
        run_until_idle(50);
        check("t6_after_mask", 64'(last_mask), 64'(2'b10));
        check("t6_after_ppn",  64'(tlb_ppn),   64'(20'h0F0F0));

        // Randomized traffic
        force_pt  = 1'b0;
        rand_mode = 1'b1;
        req_pct   = 25;
        ready_pct = 60;
        repeat (3000) step();
        rand_mode = 1'b0;
        run_until_idle(300);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
